// File: rtl/memoria_instrucciones_programable_pkg.sv
// Shared definitions for the programmable instruction memory: FSM encoding and
// the fill bits of the HALT and NOP instruction words.
package memoria_instrucciones_programable_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CARGA = 2'b01,
    LISTO = 2'b10
  } estado_t;

  localparam int BYTES_POR_PALABRA = 4;

  // HALT is all ones and NOP is all zeros at any word width, so only the fill bit is stored.
  localparam logic HALT_FILL = 1'b1;
  localparam logic NOP_FILL  = 1'b0;

endpackage

// File: rtl/memoria_instrucciones_programable_if.sv
// Fetch and program-load bus of the instruction memory.
// The master side is the fetch stage plus the loader. The slave side is the memory.
interface memoria_instrucciones_programable_if #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 64,
  parameter int NBYTE  = 8
);
  localparam int CW = $clog2(CELDAS) + 1;

  logic [NBITS-1:0] i_PC;
  logic             i_enable;
  logic             i_load_start;
  logic             i_byte_valid;
  logic [NBYTE-1:0] i_byte;
  logic [NBITS-1:0] o_Instruction;
  logic             o_halt;
  logic             o_loading;
  logic             o_load_done;
  logic [CW-1:0]    o_word_count;

  modport master (
    output i_PC, i_enable, i_load_start, i_byte_valid, i_byte,
    input  o_Instruction, o_halt, o_loading, o_load_done, o_word_count
  );

  modport slave (
    input  i_PC, i_enable, i_load_start, i_byte_valid, i_byte,
    output o_Instruction, o_halt, o_loading, o_load_done, o_word_count
  );
endinterface

// File: rtl/memoria_instrucciones_programable_ensamblador.sv
// Assembles little-endian bytes into words. o_word_valid is asserted in the same
// cycle as the fourth byte, so the word can be written into memory on that edge.
module ensamblador_palabra
  import memoria_instrucciones_programable_pkg::*;
#(
  parameter int NBYTE = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_clear,
  input  logic                                 i_en,
  input  logic                                 i_byte_valid,
  input  logic [NBYTE-1:0]                     i_byte,
  output logic [BYTES_POR_PALABRA*NBYTE-1:0]   o_word,
  output logic                                 o_word_valid
);
  localparam int W = BYTES_POR_PALABRA * NBYTE;

  logic [1:0]   byte_cnt_q;
  logic [W-1:0] asm_q, asm_d;

  always_comb begin
    asm_d = asm_q;
    asm_d[byte_cnt_q*NBYTE +: NBYTE] = i_byte;
  end

  assign o_word       = asm_d;
  assign o_word_valid = i_en && i_byte_valid && (byte_cnt_q == 2'd3);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else if (i_clear) begin
      // A restart drops any partial word.
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else if (i_en && i_byte_valid) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      asm_q      <= asm_d;
    end
  end

endmodule

// File: rtl/memoria_instrucciones_programable.sv
// Instruction memory that is loaded byte-serially and read by the fetch stage.
// Fetch has one cycle of latency and is frozen while a load is in progress.
module memoria_instrucciones_programable
  import memoria_instrucciones_programable_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int CELDAS = 64,
  parameter int NBYTE  = 8
) (
  input logic                               i_clk,
  input logic                               i_reset,
  memoria_instrucciones_programable_if.slave bus
);
  localparam int AW = $clog2(CELDAS);
  localparam logic [NBITS-1:0] HALT_W   = {NBITS{HALT_FILL}};
  localparam logic [NBITS-1:0] NOP_W    = {NBITS{NOP_FILL}};
  localparam logic [NBITS-1:0] PC_LIMIT = NBITS'(4 * CELDAS);

  estado_t          estado_q, estado_d;
  logic [AW-1:0]    wptr_q;
  logic [AW:0]      wcount_q;
  logic             done_q;
  logic [NBITS-1:0] instr_q;
  logic [NBITS-1:0] mem [CELDAS];

  logic             asm_en, word_valid, load_end, fetch;
  logic [NBITS-1:0] word;
  logic             unused_pc_lsb;

  // Fetch is word-granular, so the byte offset within a word is dropped.
  assign unused_pc_lsb = ^bus.i_PC[1:0];

  assign asm_en = (estado_q == CARGA) && !bus.i_load_start;

  ensamblador_palabra #(.NBYTE(NBYTE)) u_ensamblador (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (bus.i_load_start),
    .i_en         (asm_en),
    .i_byte_valid (bus.i_byte_valid),
    .i_byte       (bus.i_byte),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  assign load_end = word_valid && ((word == HALT_W) || (wptr_q == AW'(CELDAS - 1)));

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE:    if (bus.i_load_start) estado_d = CARGA;
      CARGA:   if (bus.i_load_start) estado_d = CARGA;
               else if (load_end)    estado_d = LISTO;
      LISTO:   if (bus.i_load_start) estado_d = CARGA;
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      estado_q <= IDLE;
      wptr_q   <= '0;
      wcount_q <= '0;
      done_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      done_q   <= load_end;
      if (bus.i_load_start) begin
        wptr_q   <= '0;
        wcount_q <= '0;
      end else if (word_valid) begin
        wptr_q   <= wptr_q + 1'b1;
        wcount_q <= wcount_q + 1'b1;
      end
    end
  end

  // The memory array has no reset, so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (word_valid) mem[wptr_q] <= word;
  end

  assign fetch = (estado_q != CARGA) && bus.i_enable;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)    instr_q <= NOP_W;
    else if (fetch) instr_q <= (bus.i_PC >= PC_LIMIT) ? NOP_W : mem[bus.i_PC[AW+1:2]];
  end

  assign bus.o_Instruction = instr_q;
  assign bus.o_halt        = (instr_q == HALT_W);
  assign bus.o_loading     = (estado_q == CARGA);
  assign bus.o_load_done   = done_q;
  assign bus.o_word_count  = wcount_q;

endmodule

// File: tb/tb_memoria_instrucciones_programable.sv
// Randomized self-checking bench. The reference model is a plain word array
// that is filled from each load's word list using the load-termination rules.
module tb_memoria_instrucciones_programable;
  localparam int NBITS  = 32;
  localparam int CELDAS = 16;
  localparam int NBYTE  = 8;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  memoria_instrucciones_programable_if #(.NBITS(NBITS), .CELDAS(CELDAS), .NBYTE(NBYTE)) bus ();

  memoria_instrucciones_programable #(.NBITS(NBITS), .CELDAS(CELDAS), .NBYTE(NBYTE)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mm    [CELDAS];
  bit          known [CELDAS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] ref_fetch(input logic [31:0] pc);
    if (pc >= 32'(4 * CELDAS)) return 32'h0;
    return mm[pc / 4];
  endfunction

  task automatic fetch(input logic [31:0] pc);
    logic [31:0] exp;
    bus.i_PC     = pc;
    bus.i_enable = 1'b1;
    step();
    exp = ref_fetch(pc);
    chk("instr", bus.o_Instruction, exp);
    chk("halt", bus.o_halt, exp == HALT);
  endtask

  // Drives every byte of every listed word. Words after the load's end arrive in LISTO and must be ignored.
  task automatic do_load(input logic [31:0] words[$], input bit gaps);
    int  n;
    bit  exp_done, exp_load;
    n = words.size();
    for (int i = 0; i < words.size(); i++)
      if (words[i] == HALT) begin n = i + 1; break; end
    if (n > CELDAS) n = CELDAS;

    bus.i_load_start = 1'b1;
    step();
    bus.i_load_start = 1'b0;
    chk("loading_entry", bus.o_loading, 1);
    chk("wc_clear", bus.o_word_count, 0);

    for (int w = 0; w < words.size(); w++) begin
      for (int b = 0; b < 4; b++) begin
        if (gaps && $urandom_range(0, 3) == 0) step();
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = words[w][8*b +: 8];
        step();
        bus.i_byte_valid = 1'b0;
        if (w < n && b == 3) begin
          mm[w]    = words[w];
          known[w] = 1'b1;
        end
        exp_done = (w == n - 1) && (b == 3);
        exp_load = (w < n - 1) || ((w == n - 1) && (b < 3));
        chk("load_done", bus.o_load_done, exp_done);
        chk("loading", bus.o_loading, exp_load);
      end
    end
    chk("word_count", bus.o_word_count, n);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    return (w == HALT) ? 32'h1 : w;
  endfunction

  initial begin
    logic [31:0] q[$];
    logic [31:0] held, w0;
    int n, idx;

    bus.i_PC = '0; bus.i_enable = 1'b0; bus.i_load_start = 1'b0;
    bus.i_byte_valid = 1'b0; bus.i_byte = '0;
    i_reset = 1'b0;
    #1 i_reset = 1'b1;
    #2;
    chk("rst_instr", bus.o_Instruction, 0);
    chk("rst_halt", bus.o_halt, 0);
    chk("rst_loading", bus.o_loading, 0);
    chk("rst_done", bus.o_load_done, 0);
    chk("rst_wc", bus.o_word_count, 0);
    @(posedge i_clk); #1 i_reset = 1'b0;

    // Fetch of the memory contents after power-up
    bus.i_PC = 0; bus.i_enable = 1'b1;
    repeat (3) begin
      step();
      chk("pwr_instr", bus.o_Instruction, 0);
      chk("pwr_halt", bus.o_halt, 0);
    end

    // Directed two-word program
    q = '{32'h0022_0021, HALT};
    do_load(q, 1'b0);
    fetch(0);
    fetch(4);
    fetch(5);

    // Enable low freezes the output
    fetch(0);
    held = bus.o_Instruction;
    bus.i_enable = 1'b0;
    repeat (3) begin
      bus.i_PC = $urandom_range(0, 4 * CELDAS - 1);
      step();
      chk("stall_hold", bus.o_Instruction, held);
    end

    // Bytes in LISTO are ignored
    repeat (8) begin
      bus.i_byte_valid = 1'b1;
      bus.i_byte = 8'($urandom);
      step();
      chk("listo_loading", bus.o_loading, 0);
    end
    bus.i_byte_valid = 1'b0;
    fetch(0);
    fetch(4);

    // Random HALT-terminated programs with gaps and trailing bytes
    repeat (4) begin
      n = $urandom_range(1, CELDAS - 2);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(rnd_word());
      q.push_back(HALT);
      q.push_back(rnd_word());
      do_load(q, 1'b1);
      repeat (10) begin
        idx = $urandom_range(0, CELDAS - 1);
        if (!known[idx]) idx = 0;
        if ($urandom_range(0, 4) == 0) fetch(32'(4 * CELDAS) + $urandom_range(0, 255));
        else fetch(32'(idx * 4) + $urandom_range(0, 3));
      end
    end

    // Full-depth load without HALT
    q = {};
    for (int i = 0; i < CELDAS + 2; i++) q.push_back(rnd_word());
    do_load(q, 1'b0);
    fetch(32'(4 * CELDAS));
    fetch(32'(4 * CELDAS - 4));
    fetch(32'hFFFF_FFFC);
    fetch(0);

    // Restart a load in the middle of a word
    bus.i_load_start = 1'b1; step(); bus.i_load_start = 1'b0;
    repeat (2) begin
      bus.i_byte_valid = 1'b1; bus.i_byte = 8'($urandom); step();
    end
    bus.i_byte_valid = 1'b0;
    w0 = rnd_word();
    q = '{w0, HALT};
    do_load(q, 1'b0);
    fetch(0);
    fetch(4);

    // Reset in the middle of a load
    bus.i_load_start = 1'b1; step(); bus.i_load_start = 1'b0;
    repeat (2) begin
      bus.i_byte_valid = 1'b1; bus.i_byte = 8'($urandom); step();
    end
    bus.i_byte_valid = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    chk("midrst_loading", bus.o_loading, 0);
    chk("midrst_done", bus.o_load_done, 0);
    chk("midrst_instr", bus.o_Instruction, 0);
    chk("midrst_wc", bus.o_word_count, 0);
    @(posedge i_clk); #1 i_reset = 1'b0;
    repeat (3) begin
      step();
      chk("midrst_nodone", bus.o_load_done, 0);
    end
    w0 = rnd_word();
    q = '{w0, HALT};
    do_load(q, 1'b0);
    fetch(0);
    fetch(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
